// File: rtl/sig_glitch_filter.sv
// sig_glitch_filter: synchronizes an async pin and debounces it with a 4-state qualifier.
// Optional rejected-transition counter enabled by defining GLITCH_FILTER_CNT_EN.
module sig_glitch_filter #(
    parameter int FILTER_W    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int GLITCH_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sig_async,
    input  logic                en,
    input  logic [FILTER_W-1:0] filter_len,
    input  logic                glitch_clr,
    output logic                sig_filtered,
    output logic                rise_pulse,
    output logic                fall_pulse,
    output logic [GLITCH_W-1:0] glitch_count
);

    typedef enum logic [1:0] {
        LOW    = 2'd0,
        QUAL_H = 2'd1,
        HIGH   = 2'd2,
        QUAL_L = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s;

    state_t                 state_q;
    state_t                 state_d;
    logic [FILTER_W-1:0]    cnt_q;
    logic [FILTER_W-1:0]    cnt_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;
    logic                   glitch_ev;

    // Shift the raw pin into the synchronizer chain; s is the last stage.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sig_async};
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Synchronizer, FSM state, qualification counter and edge strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= LOW;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next-state logic: a level change must hold for filter_len+1 FSM cycles.
    // The >= compare lets a shrinking filter_len finish at once and keeps cnt from wrapping.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        glitch_ev = 1'b0;
        unique case (state_q)
            LOW: begin
                if (s && en) begin
                    state_d = QUAL_H;
                    cnt_d   = '0;
                end
            end
            QUAL_H: begin
                if (!en) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else if (!s) begin
                    state_d   = LOW;
                    cnt_d     = '0;
                    glitch_ev = 1'b1;
                end else if (cnt_q >= filter_len) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + FILTER_W'(1);
                end
            end
            HIGH: begin
                if (!s && en) begin
                    state_d = QUAL_L;
                    cnt_d   = '0;
                end
            end
            QUAL_L: begin
                if (!en) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (s) begin
                    state_d   = HIGH;
                    cnt_d     = '0;
                    glitch_ev = 1'b1;
                end else if (cnt_q >= filter_len) begin
                    state_d = LOW;
                    cnt_d   = '0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + FILTER_W'(1);
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign sig_filtered = (state_q == HIGH) || (state_q == QUAL_L);
    assign rise_pulse   = rise_q;
    assign fall_pulse   = fall_q;

`ifdef GLITCH_FILTER_CNT_EN
    logic [GLITCH_W-1:0] glitch_q;
    logic [GLITCH_W-1:0] glitch_d;

    // Saturating glitch counter; a clear in the same cycle as a glitch wins.
    always_comb begin
        glitch_d = glitch_q;
        if (glitch_clr) begin
            glitch_d = '0;
        end else if (glitch_ev && (glitch_q != {GLITCH_W{1'b1}})) begin
            glitch_d = glitch_q + GLITCH_W'(1);
        end
    end

    // Glitch counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_count = glitch_q;
`else
    logic unused_glitch;

    assign unused_glitch = glitch_clr ^ glitch_ev;
    assign glitch_count  = '0;
`endif

endmodule

// File: tb/tb_sig_glitch_filter.sv
// tb_sig_glitch_filter: directed scenarios for the debouncing glitch filter.
// Glitch-count expectations follow whether GLITCH_FILTER_CNT_EN is defined.
module tb_sig_glitch_filter;

    localparam int FW = 8;
    localparam int GW = 2;
`ifdef GLITCH_FILTER_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          sig_async;
    logic          en;
    logic [FW-1:0] filter_len;
    logic          glitch_clr;
    logic          sig_filtered;
    logic          rise_pulse;
    logic          fall_pulse;
    logic [GW-1:0] glitch_count;

    int vecs;
    int errs;
    int rise_cnt;
    int fall_cnt;
    int both_cnt;
    int hi_cnt;
    int lo_cnt;

    sig_glitch_filter #(
        .FILTER_W   (FW),
        .SYNC_STAGES(2),
        .GLITCH_W   (GW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sig_async   (sig_async),
        .en          (en),
        .filter_len  (filter_len),
        .glitch_clr  (glitch_clr),
        .sig_filtered(sig_filtered),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .glitch_count(glitch_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [GW-1:0] exp_g(input int n);
        return CNT_ON ? GW'(n) : '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rise_pulse) rise_cnt++;
        if (fall_pulse) fall_cnt++;
        if (rise_pulse && fall_pulse) both_cnt++;
        if (sig_filtered) hi_cnt++;
        else lo_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr_mon();
        rise_cnt = 0;
        fall_cnt = 0;
        hi_cnt   = 0;
        lo_cnt   = 0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        sig_async  = 1'b1;
        en         = 1'b1;
        filter_len = '0;
        glitch_clr = 1'b0;
        ticks(6);
        vecs++;
        if (sig_filtered !== 1'b0) begin
            errs++; $display("FAIL rst_filt: got %b want 0", sig_filtered);
        end
        vecs++;
        if (rise_pulse !== 1'b0) begin
            errs++; $display("FAIL rst_rise: got %b want 0", rise_pulse);
        end
        vecs++;
        if (fall_pulse !== 1'b0) begin
            errs++; $display("FAIL rst_fall: got %b want 0", fall_pulse);
        end
        vecs++;
        if (glitch_count !== '0) begin
            errs++; $display("FAIL rst_glitch: got %0d want 0", glitch_count);
        end
        sig_async = 1'b0;
        ticks(3);
        rst = 1'b0;
        ticks(2);
    endtask

    task automatic test_len0();
        clr_mon();
        filter_len = '0;
        sig_async  = 1'b1;
        ticks(3);
        vecs++;
        if (sig_filtered !== 1'b0) begin
            errs++; $display("FAIL len0_early: got %b want 0", sig_filtered);
        end
        tick();
        vecs++;
        if (sig_filtered !== 1'b1 || rise_pulse !== 1'b1) begin
            errs++;
            $display("FAIL len0_rise: filt=%b rise=%b want 1 1", sig_filtered, rise_pulse);
        end
        tick();
        vecs++;
        if (rise_pulse !== 1'b0) begin
            errs++; $display("FAIL len0_rise_len: got %b want 0", rise_pulse);
        end
        ticks(4);
        sig_async = 1'b0;
        ticks(3);
        vecs++;
        if (sig_filtered !== 1'b1) begin
            errs++; $display("FAIL len0_fall_early: got %b want 1", sig_filtered);
        end
        tick();
        vecs++;
        if (sig_filtered !== 1'b0 || fall_pulse !== 1'b1) begin
            errs++;
            $display("FAIL len0_fall: filt=%b fall=%b want 0 1", sig_filtered, fall_pulse);
        end
        ticks(3);
        vecs++;
        if (rise_cnt !== 1 || fall_cnt !== 1) begin
            errs++;
            $display("FAIL len0_pulses: rise=%0d fall=%0d want 1 1", rise_cnt, fall_cnt);
        end
    endtask

    task automatic test_glitch();
        glitch_clr = 1'b1;
        tick();
        glitch_clr = 1'b0;
        filter_len = FW'(3);
        clr_mon();
        sig_async = 1'b1;
        ticks(3);
        sig_async = 1'b0;
        ticks(10);
        vecs++;
        if (hi_cnt !== 0 || rise_cnt !== 0 || fall_cnt !== 0) begin
            errs++;
            $display("FAIL glitch_quiet: hi=%0d rise=%0d fall=%0d want 0 0 0",
                     hi_cnt, rise_cnt, fall_cnt);
        end
        vecs++;
        if (glitch_count !== exp_g(1)) begin
            errs++; $display("FAIL glitch_one: got %0d want %0d", glitch_count, exp_g(1));
        end
    endtask

    task automatic test_clean_len3();
        clr_mon();
        filter_len = FW'(3);
        sig_async  = 1'b1;
        ticks(6);
        vecs++;
        if (sig_filtered !== 1'b0) begin
            errs++; $display("FAIL len3_rise_early: got %b want 0", sig_filtered);
        end
        tick();
        vecs++;
        if (sig_filtered !== 1'b1 || rise_pulse !== 1'b1) begin
            errs++;
            $display("FAIL len3_rise: filt=%b rise=%b want 1 1", sig_filtered, rise_pulse);
        end
        tick();
        vecs++;
        if (rise_pulse !== 1'b0) begin
            errs++; $display("FAIL len3_rise_len: got %b want 0", rise_pulse);
        end
        ticks(3);
        sig_async = 1'b0;
        ticks(6);
        vecs++;
        if (sig_filtered !== 1'b1) begin
            errs++; $display("FAIL len3_fall_early: got %b want 1", sig_filtered);
        end
        tick();
        vecs++;
        if (sig_filtered !== 1'b0 || fall_pulse !== 1'b1) begin
            errs++;
            $display("FAIL len3_fall: filt=%b fall=%b want 0 1", sig_filtered, fall_pulse);
        end
        tick();
        vecs++;
        if (fall_pulse !== 1'b0 || rise_cnt !== 1 || fall_cnt !== 1) begin
            errs++;
            $display("FAIL len3_pulses: fall=%b rise_n=%0d fall_n=%0d want 0 1 1",
                     fall_pulse, rise_cnt, fall_cnt);
        end
    endtask

    task automatic glitch1();
        sig_async = 1'b1;
        tick();
        sig_async = 1'b0;
        ticks(6);
    endtask

    task automatic test_glitch_sat();
        glitch_clr = 1'b1;
        tick();
        glitch_clr = 1'b0;
        filter_len = FW'(3);
        for (int i = 0; i < 3; i++) glitch1();
        vecs++;
        if (glitch_count !== exp_g(3)) begin
            errs++; $display("FAIL sat_three: got %0d want %0d", glitch_count, exp_g(3));
        end
        for (int i = 0; i < 2; i++) glitch1();
        vecs++;
        if (glitch_count !== exp_g(3)) begin
            errs++; $display("FAIL sat_five: got %0d want %0d", glitch_count, exp_g(3));
        end
        sig_async = 1'b1;
        tick();
        sig_async = 1'b0;
        ticks(2);
        glitch_clr = 1'b1;
        tick();
        glitch_clr = 1'b0;
        vecs++;
        if (glitch_count !== '0) begin
            errs++; $display("FAIL sat_clr_wins: got %0d want 0", glitch_count);
        end
        ticks(5);
        vecs++;
        if (glitch_count !== '0 || sig_filtered !== 1'b0) begin
            errs++;
            $display("FAIL sat_after: cnt=%0d filt=%b want 0 0", glitch_count, sig_filtered);
        end
    endtask

    task automatic test_rst_abort();
        clr_mon();
        filter_len = FW'(10);
        sig_async  = 1'b1;
        ticks(5);
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        vecs++;
        if (sig_filtered !== 1'b0 || rise_cnt !== 0) begin
            errs++;
            $display("FAIL abort_state: filt=%b rise_n=%0d want 0 0", sig_filtered, rise_cnt);
        end
        ticks(13);
        vecs++;
        if (sig_filtered !== 1'b0 || rise_cnt !== 0) begin
            errs++;
            $display("FAIL abort_restart_early: filt=%b rise_n=%0d want 0 0",
                     sig_filtered, rise_cnt);
        end
        tick();
        vecs++;
        if (sig_filtered !== 1'b1 || rise_pulse !== 1'b1) begin
            errs++;
            $display("FAIL abort_restart: filt=%b rise=%b want 1 1", sig_filtered, rise_pulse);
        end
        filter_len = '0;
        sig_async  = 1'b0;
        ticks(6);
    endtask

    task automatic test_en_drop();
        glitch_clr = 1'b1;
        tick();
        glitch_clr = 1'b0;
        filter_len = '0;
        sig_async  = 1'b1;
        ticks(6);
        clr_mon();
        filter_len = FW'(5);
        sig_async  = 1'b0;
        ticks(4);
        en = 1'b0;
        tick();
        vecs++;
        if (sig_filtered !== 1'b1) begin
            errs++; $display("FAIL endrop_hold: got %b want 1", sig_filtered);
        end
        ticks(10);
        vecs++;
        if (lo_cnt !== 0 || fall_cnt !== 0) begin
            errs++;
            $display("FAIL endrop_quiet: lo=%0d fall=%0d want 0 0", lo_cnt, fall_cnt);
        end
        vecs++;
        if (glitch_count !== exp_g(0)) begin
            errs++; $display("FAIL endrop_glitch: got %0d want %0d", glitch_count, exp_g(0));
        end
        en = 1'b1;
        ticks(6);
        vecs++;
        if (sig_filtered !== 1'b1) begin
            errs++; $display("FAIL endrop_requal_early: got %b want 1", sig_filtered);
        end
        tick();
        vecs++;
        if (sig_filtered !== 1'b0 || fall_pulse !== 1'b1) begin
            errs++;
            $display("FAIL endrop_requal: filt=%b fall=%b want 0 1", sig_filtered, fall_pulse);
        end
        ticks(2);
    endtask

    task automatic test_len_change();
        filter_len = FW'(10);
        sig_async  = 1'b1;
        ticks(5);
        filter_len = FW'(1);
        vecs++;
        if (sig_filtered !== 1'b0) begin
            errs++; $display("FAIL shrink_early: got %b want 0", sig_filtered);
        end
        tick();
        vecs++;
        if (sig_filtered !== 1'b1 || rise_pulse !== 1'b1) begin
            errs++;
            $display("FAIL shrink_done: filt=%b rise=%b want 1 1", sig_filtered, rise_pulse);
        end
        ticks(3);
        filter_len = FW'(2);
        sig_async  = 1'b0;
        ticks(4);
        filter_len = FW'(4);
        ticks(2);
        vecs++;
        if (sig_filtered !== 1'b1) begin
            errs++; $display("FAIL grow_extends: got %b want 1", sig_filtered);
        end
        ticks(2);
        vecs++;
        if (sig_filtered !== 1'b0 || fall_pulse !== 1'b1) begin
            errs++;
            $display("FAIL grow_done: filt=%b fall=%b want 0 1", sig_filtered, fall_pulse);
        end
        ticks(2);
    endtask

    task automatic test_exclusive();
        vecs++;
        if (both_cnt !== 0) begin
            errs++; $display("FAIL pulse_excl: both=%0d want 0", both_cnt);
        end
    endtask

    initial begin
        vecs       = 0;
        errs       = 0;
        both_cnt   = 0;
        rst        = 1'b1;
        sig_async  = 1'b0;
        en         = 1'b1;
        filter_len = '0;
        glitch_clr = 1'b0;
        clr_mon();
        test_reset();
        test_len0();
        test_glitch();
        test_clean_len3();
        test_glitch_sat();
        test_rst_abort();
        test_en_drop();
        test_len_change();
        test_exclusive();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/sig_glitch_filter.md
SIG_GLITCH_FILTER -- requirements
Module: sig_glitch_filter

Interface
REQ-001 Parameter FILTER_W, default 8: width of filter_len and of the qualification counter.
REQ-002 Parameter SYNC_STAGES, default 2, minimum 2: synchronizer flop count.
REQ-003 Parameter GLITCH_W, default 8: glitch counter width.
REQ-004 clk  input  1  sole clock; all state SHALL update on posedge clk.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 sig_async  input  1  raw, asynchronous pin level.
REQ-007 en  input  1  filter enable.
REQ-008 filter_len  input  FILTER_W  extra stable cycles required before accepting a level change.
REQ-009 glitch_clr  input  1  synchronous clear of glitch_count.
REQ-010 sig_filtered  output  1  debounced level; feeds the downstream rising-edge detector.
REQ-011 rise_pulse  output  1  one-cycle registered strobe on accepted 0->1.
REQ-012 fall_pulse  output  1  one-cycle registered strobe on accepted 1->0.
REQ-013 glitch_count  output  GLITCH_W  rejected-transition count.

Function
REQ-014 sig_async SHALL pass through a SYNC_STAGES flop chain; the last stage is "s".
REQ-015 FSM states SHALL be LOW, QUAL_H, HIGH and QUAL_L, with counter cnt (FILTER_W bits).
REQ-016 LOW: s=1 and en=1 -> QUAL_H, cnt<=0; otherwise hold.
REQ-017 QUAL_H: s=0 -> LOW as a glitch; s=1 and cnt>=filter_len -> HIGH; otherwise cnt<=cnt+1.
REQ-018 HIGH/QUAL_L SHALL mirror REQ-016/017 with polarity inverted (s=0 qualifies, s=1 is a glitch back to HIGH).
REQ-019 sig_filtered SHALL be 1 exactly in states HIGH and QUAL_L, registered.
REQ-020 Latency from a clean sig_async edge to the sig_filtered change SHALL be SYNC_STAGES+2+filter_len cycles.
REQ-021 rise_pulse/fall_pulse SHALL be high only in the first cycle of the new sig_filtered level, never both in one cycle.
REQ-022 The >= compare SHALL make a filter_len decrease mid-qualification complete on the next cycle; an increase extends it.
REQ-023 en=0 SHALL force QUAL_H->LOW and QUAL_L->HIGH, set cnt to 0, emit no pulse and count no glitch; the synchronizer keeps running.
REQ-024 cnt SHALL never wrap; filter_len=all-ones completes at cnt=all-ones.

Reset
REQ-025 rst=1 SHALL clear the synchronizer, cnt and glitch_count, and set state to LOW.
REQ-026 During rst: sig_filtered=0, rise_pulse=0, fall_pulse=0, glitch_count=0.
REQ-027 rst during qualification SHALL abort it with no pulse; the first cycle after release SHALL restart synchronization from 0.

Configuration
REQ-028 Macro GLITCH_FILTER_CNT_EN SHALL, when defined, enable glitch_count.
REQ-029 With GLITCH_FILTER_CNT_EN: increment by 1 on each REQ-017/018 glitch, saturate at all-ones, glitch_clr clears to 0.
REQ-030 With GLITCH_FILTER_CNT_EN, glitch_clr coincident with a glitch SHALL yield 0 (clear wins).
REQ-031 Without GLITCH_FILTER_CNT_EN: glitch_count SHALL be tied to 0, glitch_clr ignored, no counter flops; filter behaviour otherwise identical.

Verification
REQ-032 filter_len=0, en=1, sig_async 0->1 held -> sig_filtered=1 and rise_pulse high for one cycle, 4 cycles after the edge.
REQ-033 filter_len=3, sig_async high for 3 cycles then low -> sig_filtered stays 0, no pulses, glitch_count=1 (macro on).
REQ-034 filter_len=3, clean high then clean low -> rise at +7 cycles, fall 7 cycles after the falling edge, each pulse exactly one cycle.
REQ-035 GLITCH_W=2, 5 glitches then glitch_clr asserted with a 6th glitch in the same cycle -> count reads 3 after the 3rd glitch, 3 after the 5th, then 0.
REQ-036 rst asserted 2 cycles into QUAL_H with filter_len=10 -> no rise_pulse, sig_filtered=0, state LOW after release.
REQ-037 en dropped during QUAL_L -> sig_filtered stays 1, no fall_pulse, glitch_count unchanged.
